// File: rtl/alu_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_uart_pkg                                                    |
// | Purpose  : FSM encoding, status-byte layout and DATA_W legality check.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package alu_uart_pkg;

   localparam int c_STATE_W = 3;

   localparam logic [c_STATE_W-1:0] c_ST_RX_A      = 3'd0;
   localparam logic [c_STATE_W-1:0] c_ST_RX_B      = 3'd1;
   localparam logic [c_STATE_W-1:0] c_ST_RX_OP     = 3'd2;
   localparam logic [c_STATE_W-1:0] c_ST_COMPUTE   = 3'd3;
   localparam logic [c_STATE_W-1:0] c_ST_SEND      = 3'd4;
   localparam logic [c_STATE_W-1:0] c_ST_WAIT_SEND = 3'd5;

   localparam int c_STAT_ZERO_BIT  = 0;
   localparam int c_STAT_CARRY_BIT = 1;

   // Bit n set means an operand of n+1 bytes is supported.
   localparam logic [3:0] c_LEGAL_BYTES = 4'b1111;

   function automatic logic data_w_legal(input int w);
      logic ok;
      case (w)
         8:       ok = c_LEGAL_BYTES[0];
         16:      ok = c_LEGAL_BYTES[1];
         24:      ok = c_LEGAL_BYTES[2];
         32:      ok = c_LEGAL_BYTES[3];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [7:0] status_byte(input logic carry, input logic zero);
      logic [7:0] s;
      s                   = 8'h00;
      s[c_STAT_CARRY_BIT] = carry;
      s[c_STAT_ZERO_BIT]  = zero;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_timer                                                     |
// | Purpose  : Inter-byte timeout counter; expired is high on the last cycle.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;

   assign expired = enable && (r_cnt == c_LAST);

   // Restart from zero whenever the window is left, a byte arrives or it expires.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear || expired || !enable) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_uart_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_uart_frame_ctrl                                             |
// | Purpose  : UART frame decoder feeding an external ALU and returning the    |
// |            result bytes; macro ALU_UART_FLAGS_EN appends a status byte.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_uart_frame_ctrl
   import alu_uart_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_done,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [5:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              busy,
   output logic              frame_err,
   output logic              drop_err
);
   localparam int c_BYTES = DATA_W / 8;
`ifdef ALU_UART_FLAGS_EN
   localparam int c_TX_BYTES = c_BYTES + 1;
`else
   localparam int c_TX_BYTES = c_BYTES;
`endif
   localparam logic [2:0] c_LAST_BYTE = 3'(c_BYTES - 1);
   localparam logic [2:0] c_LAST_TX   = 3'(c_TX_BYTES - 1);

   generate
      if (!data_w_legal(DATA_W)) begin : g_bad_data_w
         $error("alu_uart_frame_ctrl: DATA_W must be 8, 16, 24 or 32");
      end
   endgenerate

   logic [c_STATE_W-1:0] r_state;
   logic [c_STATE_W-1:0] w_next_state;
   logic [2:0]           r_byte_cnt;
   logic [2:0]           r_tx_idx;
   logic [DATA_W-1:0]    r_sh_a;
   logic [DATA_W-1:0]    r_sh_b;
   logic [DATA_W-1:0]    r_alu_a;
   logic [DATA_W-1:0]    r_alu_b;
   logic [5:0]           r_alu_op;
   logic [DATA_W-1:0]    r_result;
   logic                 r_frame_err;
   logic                 r_drop_err;
   logic                 w_tmr_en;
   logic                 w_expired;
   logic                 w_timeout;
   logic                 w_busy;
   logic                 w_last_byte;
   logic [7:0]           w_tx_byte;

`ifdef ALU_UART_FLAGS_EN
   logic [7:0] r_status;
`else
   logic [7:0] w_unused_status;
   assign w_unused_status = status_byte(alu_carry, alu_zero);
`endif

   assign w_tmr_en    = ((r_state == c_ST_RX_A) && (r_byte_cnt != 3'd0)) ||
                        (r_state == c_ST_RX_B) || (r_state == c_ST_RX_OP);
   // A byte landing on the expiry cycle wins over the timeout.
   assign w_timeout   = w_expired && !rx_done;
   assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);

   frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (w_tmr_en),
      .clear  (rx_done),
      .expired(w_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= c_ST_RX_A;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_RX_A: begin
            if (rx_done && w_last_byte) w_next_state = c_ST_RX_B;
         end
         c_ST_RX_B: begin
            if (rx_done && w_last_byte) w_next_state = c_ST_RX_OP;
            else if (w_timeout)         w_next_state = c_ST_RX_A;
         end
         c_ST_RX_OP: begin
            if (rx_done)        w_next_state = c_ST_COMPUTE;
            else if (w_timeout) w_next_state = c_ST_RX_A;
         end
         c_ST_COMPUTE: w_next_state = c_ST_SEND;
         c_ST_SEND:    w_next_state = c_ST_WAIT_SEND;
         c_ST_WAIT_SEND: begin
            if (tx_done) w_next_state = (r_tx_idx == c_LAST_TX) ? c_ST_RX_A : c_ST_SEND;
         end
         default: w_next_state = c_ST_RX_A;
      endcase
   end

   always_comb begin
      w_tx_byte = 8'h00;
      for (int i = 0; i < c_BYTES; i++) begin
         if (r_tx_idx == 3'(i)) w_tx_byte = r_result[8*i +: 8];
      end
`ifdef ALU_UART_FLAGS_EN
      if (r_tx_idx == 3'(c_BYTES)) w_tx_byte = r_status;
`endif
   end

   always_comb begin
      tx_start = 1'b0;
      tx_data  = 8'h00;
      w_busy   = 1'b0;
      case (r_state)
         c_ST_COMPUTE: w_busy = 1'b1;
         c_ST_SEND: begin
            w_busy   = 1'b1;
            tx_start = 1'b1;
            tx_data  = w_tx_byte;
         end
         c_ST_WAIT_SEND: begin
            w_busy  = 1'b1;
            tx_data = w_tx_byte;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_byte_cnt  <= 3'd0;
         r_tx_idx    <= 3'd0;
         r_sh_a      <= '0;
         r_sh_b      <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= 6'd0;
         r_result    <= '0;
         r_frame_err <= 1'b0;
         r_drop_err  <= 1'b0;
`ifdef ALU_UART_FLAGS_EN
         r_status    <= 8'h00;
`endif
      end else begin
         r_frame_err <= w_timeout;
         r_drop_err  <= rx_done && w_busy;
         case (r_state)
            c_ST_RX_A, c_ST_RX_B: begin
               if (rx_done) begin
                  for (int i = 0; i < c_BYTES; i++) begin
                     if (r_byte_cnt == 3'(i)) begin
                        if (r_state == c_ST_RX_A) r_sh_a[8*i +: 8] <= rx_data;
                        else                      r_sh_b[8*i +: 8] <= rx_data;
                     end
                  end
                  r_byte_cnt <= w_last_byte ? 3'd0 : r_byte_cnt + 3'd1;
               end else if (w_timeout) begin
                  r_byte_cnt <= 3'd0;
               end
            end
            c_ST_RX_OP: begin
               if (rx_done) begin
                  r_alu_a  <= r_sh_a;
                  r_alu_b  <= r_sh_b;
                  r_alu_op <= rx_data[5:0];
               end
               r_byte_cnt <= 3'd0;
            end
            c_ST_COMPUTE: begin
               r_result <= alu_result;
               r_tx_idx <= 3'd0;
`ifdef ALU_UART_FLAGS_EN
               r_status <= status_byte(alu_carry, alu_zero);
`endif
            end
            c_ST_WAIT_SEND: begin
               if (tx_done) r_tx_idx <= (r_tx_idx == c_LAST_TX) ? 3'd0 : r_tx_idx + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign busy      = w_busy;
   assign frame_err = r_frame_err;
   assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_uart_frame_ctrl                                          |
// | Purpose  : Directed and random frames on 16-bit and 8-bit instances.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_uart_frame_ctrl;
   localparam int c_TMO    = 50;
   localparam int c_TX_DLY = 4;
`ifdef ALU_UART_FLAGS_EN
   localparam int c_EXTRA = 1;
`else
   localparam int c_EXTRA = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [7:0]  rx_data16, tx_data16, rx_data8, tx_data8;
   logic        rx_done16, tx_start16, tx_done16, busy16, ferr16, derr16;
   logic        rx_done8, tx_start8, tx_done8, busy8, ferr8, derr8;
   logic [15:0] alu_a16, alu_b16, alu_res16;
   logic [7:0]  alu_a8, alu_b8, alu_res8;
   logic [5:0]  alu_op16, alu_op8;
   logic        zero16, carry16, zero8, carry8;
   logic [33:0] w_alu16, w_alu8;

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] q16[$];
   logic [7:0] q8[$];

   // External ALU: returns {zero, carry, result}.
   function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] op, input int w);
      longint unsigned la, lb, mask, r;
      logic c;
      la = 64'(a); lb = 64'(b); mask = (64'd1 << w) - 64'd1; c = 1'b0;
      case (op)
         6'h22: begin r = (la - lb) & mask; c = (la < lb); end
         6'h24: r = la & lb;
         6'h25: r = la | lb;
         6'h26: r = la ^ lb;
         default: begin r = la + lb; c = ((r >> w) & 64'd1) != 0; r = r & mask; end
      endcase
      return {(r == 0), c, r[31:0]};
   endfunction

   assign w_alu16   = alu_model({16'h0, alu_a16}, {16'h0, alu_b16}, alu_op16, 16);
   assign alu_res16 = w_alu16[15:0];
   assign carry16   = w_alu16[32];
   assign zero16    = w_alu16[33];
   assign w_alu8    = alu_model({24'h0, alu_a8}, {24'h0, alu_b8}, alu_op8, 8);
   assign alu_res8  = w_alu8[7:0];
   assign carry8    = w_alu8[32];
   assign zero8     = w_alu8[33];

   alu_uart_frame_ctrl #(.DATA_W(16), .TIMEOUT_CYCLES(c_TMO)) u_dut16 (
      .clk(clk), .reset(reset), .rx_data(rx_data16), .rx_done(rx_done16),
      .tx_data(tx_data16), .tx_start(tx_start16), .tx_done(tx_done16),
      .alu_a(alu_a16), .alu_b(alu_b16), .alu_op(alu_op16), .alu_result(alu_res16),
      .alu_zero(zero16), .alu_carry(carry16), .busy(busy16),
      .frame_err(ferr16), .drop_err(derr16)
   );

   alu_uart_frame_ctrl #(.DATA_W(8), .TIMEOUT_CYCLES(c_TMO)) u_dut8 (
      .clk(clk), .reset(reset), .rx_data(rx_data8), .rx_done(rx_done8),
      .tx_data(tx_data8), .tx_start(tx_start8), .tx_done(tx_done8),
      .alu_a(alu_a8), .alu_b(alu_b8), .alu_op(alu_op8), .alu_result(alu_res8),
      .alu_zero(zero8), .alu_carry(carry8), .busy(busy8),
      .frame_err(ferr8), .drop_err(derr8)
   );

   // UART transmitter stand-ins: record each requested byte, answer tx_done later.
   initial begin
      tx_done16 = 1'b0;
      forever begin
         @(negedge clk);
         tx_done16 = 1'b0;
         if (tx_start16) begin
            q16.push_back(tx_data16);
            repeat (c_TX_DLY - 1) @(negedge clk);
            tx_done16 = 1'b1;
         end
      end
   end

   initial begin
      tx_done8 = 1'b0;
      forever begin
         @(negedge clk);
         tx_done8 = 1'b0;
         if (tx_start8) begin
            q8.push_back(tx_data8);
            repeat (c_TX_DLY - 1) @(negedge clk);
            tx_done8 = 1'b1;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int which);
      return (which == 8) ? q8.size() : q16.size();
   endfunction

   task automatic send_byte(input int which, input logic [7:0] b);
      @(negedge clk);
      if (which == 8) begin rx_data8 = b; rx_done8 = 1'b1; end
      else            begin rx_data16 = b; rx_done16 = 1'b1; end
      @(negedge clk);
      rx_done8  = 1'b0;
      rx_done16 = 1'b0;
   endtask

   task automatic send_frame16(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb);
      send_byte(16, a[7:0]);
      send_byte(16, a[15:8]);
      send_byte(16, b[7:0]);
      send_byte(16, b[15:8]);
      send_byte(16, opb);
   endtask

   task automatic check_idle16(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [5:0] op);
      check({tag, "/tx_data"},  32'(tx_data16), 32'h00);
      check({tag, "/tx_start"}, 32'(tx_start16), 32'h0);
      check({tag, "/busy"},     32'(busy16), 32'h0);
      check({tag, "/frame_err"}, 32'(ferr16), 32'h0);
      check({tag, "/drop_err"}, 32'(derr16), 32'h0);
      check({tag, "/alu_a"},    32'(alu_a16), 32'(a));
      check({tag, "/alu_b"},    32'(alu_b16), 32'(b));
      check({tag, "/alu_op"},   32'(alu_op16), 32'(op));
   endtask

   // Waits for the whole reply, then compares operands and every byte to the model.
   task automatic check_frame(input int which, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] opb, input string tag);
      int w, n, cyc;
      logic [33:0] t;
      logic [7:0] e, o;
      w = (which == 8) ? 8 : 16;
      n = w / 8 + c_EXTRA;
      t = alu_model(a, b, opb[5:0], w);
      cyc = 0;
      while (qsize(which) < n && cyc < 400) begin @(negedge clk); cyc++; end
      while (((which == 8) ? busy8 : busy16) && cyc < 800) begin @(negedge clk); cyc++; end
      check({tag, "/tx_count"}, 32'(qsize(which)), 32'(n));
      check({tag, "/alu_a"}, (which == 8) ? 32'(alu_a8) : 32'(alu_a16), a);
      check({tag, "/alu_b"}, (which == 8) ? 32'(alu_b8) : 32'(alu_b16), b);
      check({tag, "/alu_op"}, (which == 8) ? 32'(alu_op8) : 32'(alu_op16), 32'(opb[5:0]));
      for (int i = 0; i < n; i++) begin
         if (i < w / 8) e = t[8*i +: 8];
         else           e = {6'b0, t[32], t[33]};
         o = 8'hxx;
         if (i < qsize(which)) o = (which == 8) ? q8[i] : q16[i];
         check($sformatf("%s/tx%0d", tag, i), 32'(o), 32'(e));
      end
      q8.delete();
      q16.delete();
   endtask

   initial begin
      logic [15:0] a, b, last_a, last_b;
      logic [7:0]  opb, a8, b8;
      logic [5:0]  last_op;
      logic [5:0]  ops[5];
      int pulses, first, cyc;
      ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25; ops[4] = 6'h26;

      reset = 1'b0;
      rx_data16 = 8'h00; rx_done16 = 1'b0;
      rx_data8  = 8'h00; rx_done8  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle16("reset", 16'h0, 16'h0, 6'h0);
      check("reset/tx_data8", 32'(tx_data8), 32'h00);
      check("reset/alu_a8", 32'(alu_a8), 32'h00);
      reset = 1'b1;
      @(negedge clk);

      // Reference frame 34 12 01 00 20, including the 2-cycle reply latency.
      send_frame16(16'h1234, 16'h0001, 8'h20);
      check("lat/compute_tx_start", 32'(tx_start16), 32'h0);
      check("lat/compute_busy", 32'(busy16), 32'h1);
      @(negedge clk);
      check("lat/send_tx_start", 32'(tx_start16), 32'h1);
      check_frame(16, 32'h1234, 32'h0001, 8'h20, "f16_ref");

      // 8-bit overflow: FF + 01 -> 00 with carry and zero.
      send_byte(8, 8'hFF);
      send_byte(8, 8'h01);
      send_byte(8, 8'h20);
      check_frame(8, 32'hFF, 32'h01, 8'h20, "f8_carry");

      // Inter-byte silence after the first byte of A.
      send_byte(16, 8'h34);
      pulses = 0; first = -1;
      for (int c = 1; c <= 60; c++) begin
         if (ferr16) begin pulses++; if (first < 0) first = c; end
         @(negedge clk);
      end
      check("tmo/pulses", 32'(pulses), 32'd1);
      check("tmo/window", 32'(first >= 49 && first <= 53), 32'd1);
      check("tmo/alu_a_kept", 32'(alu_a16), 32'h1234);
      check("tmo/alu_b_kept", 32'(alu_b16), 32'h0001);
      check("tmo/busy", 32'(busy16), 32'h0);
      a = 16'($urandom); b = 16'($urandom);
      send_frame16(a, b, 8'h20);
      check_frame(16, 32'(a), 32'(b), 8'h20, "tmo/next_frame");

      // Second byte arrives exactly on the expiry cycle.
      send_byte(16, 8'h78);
      pulses = 0;
      repeat (48) begin @(negedge clk); if (ferr16) pulses++; end
      send_byte(16, 8'h56);
      if (ferr16) pulses++;
      check("coinc/frame_err", 32'(pulses), 32'd0);
      send_byte(16, 8'h0F);
      send_byte(16, 8'h00);
      send_byte(16, 8'h22);
      check_frame(16, 32'h5678, 32'h000F, 8'h22, "coinc/frame");

      // Byte injected while waiting for tx_done is dropped.
      a = 16'($urandom); b = 16'($urandom);
      send_frame16(a, b, 8'h26);
      cyc = 0;
      while (q16.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
      send_byte(16, 8'hA5);
      check("drop/pulse", 32'(derr16), 32'h1);
      check("drop/busy", 32'(busy16), 32'h1);
      check_frame(16, 32'(a), 32'(b), 8'h26, "drop/frame");
      a = 16'($urandom); b = 16'($urandom);
      send_frame16(a, b, 8'h25);
      check_frame(16, 32'(a), 32'(b), 8'h25, "drop/next_frame");

      // Reset between result bytes.
      a = 16'($urandom); b = 16'($urandom);
      send_frame16(a, b, 8'h20);
      cyc = 0;
      while (q16.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_idle16("midrst", 16'h0, 16'h0, 6'h0);
      repeat (20) @(negedge clk);
      check("midrst/no_more_tx", 32'(q16.size()), 32'd1);
      q16.delete();
      q8.delete();

      // Random frames on both widths.
      for (int k = 0; k < 12; k++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]};
         send_frame16(a, b, opb);
         check_frame(16, 32'(a), 32'(b), opb, $sformatf("rnd16_%0d", k));
      end
      last_a = a; last_b = b; last_op = opb[5:0];
      for (int k = 0; k < 6; k++) begin
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]};
         send_byte(8, a8);
         send_byte(8, b8);
         send_byte(8, opb);
         check_frame(8, 32'(a8), 32'(b8), opb, $sformatf("rnd8_%0d", k));
      end
      check_idle16("final16", last_a, last_b, last_op);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
